ospfb_sched: RTL and testbench

- Input sequencer for the oversampled PFB polyphase FIR datapath.
- Converts a continuous AXI-Stream sample feed into the FORWARD/FEEDBACK cycle schedule the PE chain requires: DEC_FAC new samples, then FFT_LEN-DEC_FAC feedback cycles, per FFT_LEN-cycle frame.
- Generates the datapath enable/valid/data and the per-frame phase-rotation index for downstream phase compensation.
- Monitors both stream interfaces for underrun and dropped-output errors.

---
 rtl/ospfb_sched.sv | 136 +++++++++++++
 tb/tb_ospfb_sched.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ospfb_sched.sv
// Input sequencer for the oversampled PFB: turns a sample stream into the
// FORWARD/FEEDBACK frame schedule and tracks stream errors.
module ospfb_sched #(
  parameter int WIDTH   = 16,
  parameter int FFT_LEN = 32,
  parameter int DEC_FAC = 24,
  parameter int CNT_WID = 16,
  localparam int LW     = $clog2(FFT_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               err_clr,
  input  logic               s_axis_tvalid,
  input  logic [WIDTH-1:0]   s_axis_tdata,
  output logic               s_axis_tready,
  input  logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               pe_en,
  output logic               pe_vin,
  output logic [WIDTH-1:0]   pe_din,
  output logic               frame_start,
  output logic [LW-1:0]      modtimer,
  output logic [LW-1:0]      shift_idx,
  output logic               err_underrun,
  output logic               err_drop,
  output logic [CNT_WID-1:0] underrun_cnt
);

  if (DEC_FAC <= 0 || DEC_FAC >= FFT_LEN) begin : g_bad_dec
    $error("ospfb_sched: DEC_FAC must satisfy 0 < DEC_FAC < FFT_LEN");
  end

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FORWARD  = 2'd1,
    FEEDBACK = 2'd2
  } state_t;

  localparam logic [LW-1:0] FWD_LAST = LW'(DEC_FAC - 1);
  localparam logic [LW-1:0] FB_LAST  = LW'(FFT_LEN - 1);
  localparam logic [LW-1:0] SHIFT_STEP = LW'(DEC_FAC);

  state_t             state_q, state_d;
  logic [LW-1:0]      mt_q, mt_d;
  logic [LW-1:0]      sh_q, sh_d;
  logic               eu_q, eu_d;
  logic               ed_q, ed_d;
  logic [CNT_WID-1:0] cnt_q, cnt_d;

  logic fwd, underrun, drop;

  assign fwd      = (state_q == FORWARD);
  assign underrun = fwd && en && !s_axis_tvalid;
  assign drop     = m_axis_tvalid && !m_axis_tready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mt_q    <= '0;
      sh_q    <= '0;
      eu_q    <= 1'b0;
      ed_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mt_q    <= mt_d;
      sh_q    <= sh_d;
      eu_q    <= eu_d;
      ed_q    <= ed_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mt_d    = mt_q;
    sh_d    = sh_q;
    unique case (state_q)
      IDLE: begin
        if (en && s_axis_tvalid) begin
          state_d = FORWARD;
          mt_d    = '0;
        end
      end
      FORWARD: begin
        if (en) begin
          mt_d = mt_q + 1'b1;
          if (mt_q == FWD_LAST) state_d = FEEDBACK;
        end
      end
      FEEDBACK: begin
        if (en) begin
          mt_d = mt_q + 1'b1;
          if (mt_q == FB_LAST) begin
            state_d = FORWARD;
            sh_d    = sh_q + SHIFT_STEP;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A new event in the same cycle as err_clr takes precedence over the clear.
  always_comb begin
    eu_d  = eu_q;
    ed_d  = ed_q;
    cnt_d = cnt_q;
    if (err_clr) begin
      eu_d  = 1'b0;
      ed_d  = 1'b0;
      cnt_d = '0;
    end
    if (underrun) begin
      eu_d = 1'b1;
      if (err_clr)
        cnt_d = CNT_WID'(1);
      else if (cnt_q != '1)
        cnt_d = cnt_q + 1'b1;
    end
    if (drop) ed_d = 1'b1;
  end

  assign s_axis_tready = fwd && en;
  assign pe_vin        = fwd && en;
  assign pe_en         = en && (state_q != IDLE);
  assign pe_din        = (fwd && s_axis_tvalid) ? s_axis_tdata : '0;
  assign frame_start   = fwd && en && (mt_q == '0);
  assign modtimer      = mt_q;
  assign shift_idx     = sh_q;
  assign err_underrun  = eu_q;
  assign err_drop      = ed_q;
  assign underrun_cnt  = cnt_q;

endmodule

// File: tb/tb_ospfb_sched.sv
// Directed bench for ospfb_sched: schedule, phase index, underrun,
// enable hold, drop flag, error clear and mid-frame reset.
module tb_ospfb_sched;

  logic        clk = 1'b0;
  logic        rst, en, err_clr;
  logic        s_axis_tvalid, s_axis_tready;
  logic [15:0] s_axis_tdata;
  logic        m_axis_tvalid, m_axis_tready;
  logic        pe_en, pe_vin, frame_start;
  logic [15:0] pe_din;
  logic [4:0]  modtimer, shift_idx;
  logic        err_underrun, err_drop;
  logic [15:0] underrun_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  ospfb_sched dut (
    .clk(clk), .rst(rst), .en(en), .err_clr(err_clr),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata),
    .s_axis_tready(s_axis_tready),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .pe_en(pe_en), .pe_vin(pe_vin), .pe_din(pe_din),
    .frame_start(frame_start), .modtimer(modtimer),
    .shift_idx(shift_idx), .err_underrun(err_underrun),
    .err_drop(err_drop), .underrun_cnt(underrun_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    int d;
    int mt;
    int acc;
    bit done;
    bit f;
    logic [4:0] sh_tab [0:4];
    sh_tab[0] = 5'd0;  sh_tab[1] = 5'd24; sh_tab[2] = 5'd16;
    sh_tab[3] = 5'd8;  sh_tab[4] = 5'd0;

    rst = 1; en = 0; err_clr = 0;
    s_axis_tvalid = 0; s_axis_tdata = 0;
    m_axis_tvalid = 0; m_axis_tready = 1;
    tick(); tick();
    rst = 0;
    #4;
    chk("rst_mt", modtimer, 0);
    chk("rst_sh", shift_idx, 0);
    chk("rst_eu", err_underrun, 0);
    chk("rst_ed", err_drop, 0);
    chk("rst_cnt", underrun_cnt, 0);
    chk("rst_rdy", s_axis_tready, 0);
    chk("rst_peen", pe_en, 0);

    // Ramp over two frames
    en = 1; s_axis_tvalid = 1; d = 1; s_axis_tdata = 16'(d);
    #1;
    chk("idle_rdy", s_axis_tready, 0);
    chk("idle_peen", pe_en, 0);
    tick();
    for (int c = 0; c < 64; c++) begin
      mt = c % 32;
      f = (mt < 24);
      s_axis_tdata = 16'(d);
      #4;
      chk("ramp_mt", modtimer, 32'(mt));
      chk("ramp_rdy", s_axis_tready, 32'(f));
      chk("ramp_vin", pe_vin, 32'(f));
      chk("ramp_peen", pe_en, 1);
      chk("ramp_fs", frame_start, 32'(mt == 0));
      chk("ramp_din", pe_din, f ? 32'(d) : 0);
      chk("ramp_sh", shift_idx, sh_tab[c / 32]);
      if (f) d++;
      tick();
    end

    for (int fr = 2; fr < 5; fr++) begin
      #4;
      chk("sh_frame", shift_idx, sh_tab[fr]);
      chk("sh_mt", modtimer, 0);
      repeat (32) tick();
    end

    // Underrun at modtimer 5..7 of frame 5
    repeat (5) tick();
    for (int i = 0; i < 3; i++) begin
      s_axis_tvalid = 0;
      #4;
      chk("ur_mt", modtimer, 32'(5 + i));
      chk("ur_vin", pe_vin, 1);
      chk("ur_din", pe_din, 0);
      chk("ur_rdy", s_axis_tready, 1);
      tick();
    end
    s_axis_tvalid = 1;
    #4;
    chk("ur_flag", err_underrun, 1);
    chk("ur_cnt", underrun_cnt, 3);
    chk("ur_mt8", modtimer, 8);
    tick();
    repeat (15) tick();
    s_axis_tvalid = 0;
    for (int i = 0; i < 8; i++) begin
      #4;
      chk("fb_mt", modtimer, 32'(24 + i));
      chk("fb_rdy", s_axis_tready, 0);
      tick();
    end
    s_axis_tvalid = 1;
    #4;
    chk("ur_wrap_mt", modtimer, 0);
    chk("ur_wrap_fs", frame_start, 1);
    chk("fb_nocnt", underrun_cnt, 3);
    tick();

    // en dropped at modtimer 20 of frame 6
    repeat (19) tick();
    en = 0; s_axis_tvalid = 0;
    for (int i = 0; i < 4; i++) begin
      #4;
      chk("en_mt", modtimer, 20);
      chk("en_rdy", s_axis_tready, 0);
      chk("en_peen", pe_en, 0);
      chk("en_vin", pe_vin, 0);
      chk("en_cnt", underrun_cnt, 3);
      tick();
    end
    en = 1; s_axis_tvalid = 1;
    acc = 0; done = 0;
    for (int i = 0; i < 10 && !done; i++) begin
      #4;
      if (s_axis_tready) begin
        acc++;
        tick();
      end else begin
        done = 1;
      end
    end
    chk("en_acc", acc, 4);
    chk("en_fb_mt", modtimer, 24);

    // Dropped output, sticky, then cleared
    m_axis_tvalid = 1; m_axis_tready = 0;
    tick();
    m_axis_tvalid = 0; m_axis_tready = 1;
    #4;
    chk("drop_set", err_drop, 1);
    tick();
    #4;
    chk("drop_hold", err_drop, 1);
    err_clr = 1;
    tick();
    err_clr = 0;
    #4;
    chk("clr_drop", err_drop, 0);
    chk("clr_eu", err_underrun, 0);
    chk("clr_cnt", underrun_cnt, 0);

    // Clear coincident with an underrun, frame 7 modtimer 0
    repeat (5) tick();
    s_axis_tvalid = 0; err_clr = 1;
    #4;
    chk("co_fs", frame_start, 1);
    chk("co_sh", shift_idx, 8);
    tick();
    s_axis_tvalid = 1; err_clr = 0;
    #4;
    chk("co_eu", err_underrun, 1);
    chk("co_cnt", underrun_cnt, 1);

    // Reset during FEEDBACK of frame 10
    repeat (123) tick();
    #4;
    chk("pre_rst_mt", modtimer, 28);
    chk("pre_rst_sh", shift_idx, 16);
    rst = 1;
    tick();
    rst = 0; s_axis_tvalid = 0;
    #4;
    chk("mrst_mt", modtimer, 0);
    chk("mrst_sh", shift_idx, 0);
    chk("mrst_eu", err_underrun, 0);
    chk("mrst_cnt", underrun_cnt, 0);
    chk("mrst_rdy", s_axis_tready, 0);
    chk("mrst_peen", pe_en, 0);
    chk("mrst_vin", pe_vin, 0);
    chk("mrst_din", pe_din, 0);
    chk("mrst_fs", frame_start, 0);
    tick(); tick();
    #4;
    chk("wait_peen", pe_en, 0);
    chk("wait_mt", modtimer, 0);
    s_axis_tvalid = 1; s_axis_tdata = 16'h0055;
    #1;
    chk("wait_rdy", s_axis_tready, 0);
    tick();
    #4;
    chk("restart_rdy", s_axis_tready, 1);
    chk("restart_din", pe_din, 32'h55);
    chk("restart_fs", frame_start, 1);
    chk("restart_vin", pe_vin, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
